// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back merge of ALU results and FIFO-buffered loads; define WB_WAW_KILL_EN for WAW squash
module wb_arbiter #(
  parameter int N = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_we,
  input  logic [4:0]               alu_wa,
  input  logic [N-1:0]             alu_wd,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_wa,
  input  logic [N-1:0]             ld_wd,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [N-1:0]             wd3,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]    q_wa [DEPTH];
  logic [N-1:0]  q_wd [DEPTH];
  logic [AW-1:0] head, tail;
  logic          alu_eff, push, pop, head_live;
  assign alu_eff  = alu_we && alu_wa != 5'd31;
  assign ld_ready = count < (AW+1)'(DEPTH);
  assign push     = ld_valid && ld_ready && ld_wa != 5'd31;
  assign busy     = count != '0;
  assign pop      = !alu_eff && busy;
`ifdef WB_WAW_KILL_EN
  logic [DEPTH-1:0] live;
  assign head_live = live[head];
`else
  assign head_live = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      count <= '0;
      head  <= '0;
      tail  <= '0;
`ifdef WB_WAW_KILL_EN
      live  <= '0;
`endif
    end else begin
      we3 <= alu_eff || (pop && head_live);
      if (alu_eff) begin
        wa3 <= alu_wa;
        wd3 <= alu_wd;
      end else if (pop) begin
        wa3 <= q_wa[head];
        wd3 <= q_wd[head];
      end
      if (push) begin
        q_wa[tail] <= ld_wa;
        q_wd[tail] <= ld_wd;
        tail       <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
`ifdef WB_WAW_KILL_EN
      for (int i = 0; i < DEPTH; i++)
        if (alu_eff && q_wa[i] == alu_wa) live[i] <= 1'b0;
      // a load arriving alongside a same-address ALU write is the older of the two
      if (push) live[tail] <= !(alu_eff && ld_wa == alu_wa);
`endif
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
`ifdef WB_WAW_KILL_EN
  localparam bit KILL = 1'b1;
`else
  localparam bit KILL = 1'b0;
`endif
  logic        clk, reset, alu_we, ld_valid, ld_ready, we3, busy;
  logic [4:0]  alu_wa, ld_wa, wa3;
  logic [63:0] alu_wd, ld_wd, wd3;
  logic [2:0]  count;
  logic [63:0] rf [32];
  int checks = 0, failures = 0;
  int pw [5] = '{21, 23, 24, 25, 26};
  wb_arbiter dut (
    .clk(clk), .reset(reset), .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .count(count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (we3) rf[wa3] <= wd3;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic expect_out(input logic e_we, input logic [4:0] e_wa, input logic [63:0] e_wd);
    chk("we3", 64'(we3), 64'(e_we));
    chk("wa3", 64'(wa3), 64'(e_wa));
    chk("wd3", wd3, e_wd);
  endtask
  task automatic expect_q(input logic [2:0] e_cnt, input logic e_rdy);
    chk("count", 64'(count), 64'(e_cnt));
    chk("ld_ready", 64'(ld_ready), 64'(e_rdy));
    chk("busy", 64'(busy), 64'(e_cnt != 3'd0));
  endtask
  initial begin
    reset = 1; alu_we = 1; alu_wa = 5; alu_wd = 64'h9; ld_valid = 1; ld_wa = 3; ld_wd = 64'h77;
    repeat (2) begin
      step(); expect_out(0, 0, 0); expect_q(0, 1);
    end
    reset = 0; alu_we = 0; ld_valid = 0;
    step(); expect_out(0, 0, 0); expect_q(0, 1);
    alu_we = 1; alu_wa = 5; alu_wd = 64'h1234;
    step(); expect_out(1, 5, 64'h1234);
    alu_wa = 31; alu_wd = 64'h55;
    step(); expect_out(0, 5, 64'h1234); expect_q(0, 1);
    for (int c = 0; c < 6; c++) begin
      alu_wa = 5'(10 + c); alu_wd = 64'(500 + c); ld_valid = 1;
      ld_wa = c < 4 ? 5'(1 + c) : 5'd9;
      ld_wd = c < 4 ? 64'(100 + c) : 64'd999;
      step(); expect_out(1, 5'(10 + c), 64'(500 + c));
      expect_q(c < 4 ? 3'(c + 1) : 3'd4, c < 3);
    end
    alu_we = 0;
    step(); expect_out(1, 1, 100); expect_q(3, 1);
    step(); expect_out(1, 2, 101); expect_q(3, 1);
    ld_valid = 0;
    step(); expect_out(1, 3, 102); expect_q(2, 1);
    step(); expect_out(1, 4, 103); expect_q(1, 1);
    step(); expect_out(1, 9, 999); expect_q(0, 1);
    step(); expect_out(0, 9, 999); expect_q(0, 1);
    alu_we = 1; alu_wa = 20; alu_wd = 20; ld_valid = 1; ld_wa = 21; ld_wd = 121;
    step(); expect_out(1, 20, 20); expect_q(1, 1);
    alu_wa = 22; alu_wd = 22; ld_wa = 23; ld_wd = 123;
    step(); expect_out(1, 22, 22); expect_q(2, 1);
    alu_we = 0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = i < 3; ld_wa = 5'(24 + i); ld_wd = 64'(124 + i);
      step(); expect_out(1, 5'(pw[i]), 64'(100 + pw[i]));
      expect_q(i < 3 ? 3'd2 : 3'(4 - i), 1);
    end
    ld_valid = 1; ld_wa = 7; ld_wd = 100;
    step(); expect_out(0, 26, 126); expect_q(1, 1);
    ld_valid = 0; alu_we = 1; alu_wa = 7; alu_wd = 200;
    step(); expect_out(1, 7, 200); expect_q(1, 1);
    alu_we = 0;
    step(); expect_out(!KILL, 7, 100); expect_q(0, 1);
    step(); chk("rf_x7", rf[7], KILL ? 64'd200 : 64'd100);
    alu_we = 1; alu_wa = 8; alu_wd = 300; ld_valid = 1; ld_wa = 8; ld_wd = 150;
    step(); expect_out(1, 8, 300); expect_q(1, 1);
    alu_we = 0; ld_valid = 0;
    step(); expect_out(!KILL, 8, 150); expect_q(0, 1);
    step(); chk("rf_x8", rf[8], KILL ? 64'd300 : 64'd150);
    ld_valid = 1; ld_wa = 31; ld_wd = 5;
    step(); expect_out(0, 8, 150); expect_q(0, 1);
    ld_valid = 0; alu_we = 1;
    for (int c = 0; c < 3; c++) begin
      alu_wa = 5'(12 + c); alu_wd = 64'(c); ld_valid = 1; ld_wa = 5'(16 + c); ld_wd = 64'(600 + c);
      step();
    end
    expect_out(1, 14, 2); expect_q(3, 1);
    reset = 1; alu_we = 0; ld_valid = 0;
    step(); expect_out(0, 0, 0); expect_q(0, 1);
    reset = 0;
    repeat (3) begin
      step(); expect_out(0, 0, 0); expect_q(0, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
